// File: rtl/matrix_mult_seq.sv
// Sequential N x N matrix multiplier: one multiply-accumulate per cycle.
// Computes C = A*B, or C = C_prev + A*B in accumulate mode, and presents
// the finished matrix on c_flat in a single atomic update.
module matrix_mult_seq #(
    parameter int DW       = 32,
    parameter int N        = 4,
    parameter int OUT_HOLD = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              acc_mode,
    input  logic [N*N*DW-1:0] a_flat,
    input  logic [N*N*DW-1:0] b_flat,
    output logic [N*N*DW-1:0] c_flat,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    // A sum of up to eight 2*DW-bit products fits in 2*DW+3 bits; one spare bit.
    localparam int AW = 2 * DW + 4;
    localparam logic [IW-1:0] IMAX = IW'(N - 1);

    logic [1:0]        state_q, state_d;
    logic [IW-1:0]     i_q, i_d, j_q, j_d, k_q, k_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [7:0]        hold_q, hold_d;
    logic              mode_q, mode_d;
    logic [N*N*DW-1:0] c_q, c_d;
    logic [N*N*DW-1:0] res_q, res_d;
    logic [N*N*DW-1:0] a_q, b_q;
    logic              capture;

    logic [DW-1:0] a_elem, b_elem, cprev_elem, elem;
    logic [AW-1:0] prod, sum;
    logic          last_k, last_all;

    // Operand selection; c_q is untouched during MAC, so it still holds C_prev.
    assign a_elem     = a_q[(int'(i_q) * N + int'(k_q)) * DW +: DW];
    assign b_elem     = b_q[(int'(k_q) * N + int'(j_q)) * DW +: DW];
    assign cprev_elem = c_q[(int'(i_q) * N + int'(j_q)) * DW +: DW];
    assign prod       = AW'(a_elem) * AW'(b_elem);
    assign sum        = acc_q + prod;
    // Only the low DW bits are stored, so the C_prev add can be done at DW width.
    assign elem       = DW'(sum) + (mode_q ? cprev_elem : '0);
    assign last_k     = (k_q == IMAX);
    assign last_all   = last_k && (j_q == IMAX) && (i_q == IMAX);

    // Next-state logic for the FSM, indices, accumulator and result buffers.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        acc_d   = acc_q;
        hold_d  = hold_q;
        mode_d  = mode_q;
        c_d     = c_q;
        res_d   = res_q;
        capture = 1'b0;

        if (state_q == S_MAC && last_k) begin
            res_d[(int'(i_q) * N + int'(j_q)) * DW +: DW] = elem;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    capture = 1'b1;
                    mode_d  = acc_mode;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                if (last_k) begin
                    acc_d = '0;
                    k_d   = '0;
                    if (j_q == IMAX) begin
                        j_d = '0;
                        i_d = (i_q == IMAX) ? '0 : i_q + 1'b1;
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end else begin
                    acc_d = sum;
                    k_d   = k_q + 1'b1;
                end
                if (last_all) begin
                    c_d     = res_d;
                    hold_d  = 8'(OUT_HOLD - 1);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (hold_q == 8'd0) begin
                    state_d = S_IDLE;
                end else begin
                    hold_d = hold_q - 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state and the visible result register, synchronously reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (rst) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            hold_q  <= '0;
            mode_q  <= 1'b0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            hold_q  <= hold_d;
            mode_q  <= mode_d;
            c_q     <= c_d;
        end
    end

    // Operand and partial-result storage.
    always_ff @(posedge clk) begin
        // NOTE: these wide arrays are not reset; operands are recaptured on every
        // start and each result element is rewritten before it can reach c_flat.
        if (capture) begin
            a_q <= a_flat;
            b_q <= b_flat;
        end
        res_q <= res_d;
    end

    assign c_flat = c_q;
    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_matrix_mult_seq.sv
// Self-checking bench for matrix_mult_seq (N=4, DW=32, OUT_HOLD=10).
module tb_matrix_mult_seq;

    localparam int DW       = 32;
    localparam int N        = 4;
    localparam int OUT_HOLD = 10;
    localparam int MAC_CYC  = N * N * N;

    typedef logic [N*N*DW-1:0] mat_t;

    logic clk = 1'b0;
    logic rst, start, acc_mode, busy, done;
    mat_t a_flat, b_flat, c_flat;

    int   n_checks = 0;
    int   n_errors = 0;
    mat_t exp_q[$];
    mat_t model_c;
    mat_t ident, bseq, ones, ra, rb;

    matrix_mult_seq #(.DW(DW), .N(N), .OUT_HOLD(OUT_HOLD)) dut (
        .clk(clk), .rst(rst), .start(start), .acc_mode(acc_mode),
        .a_flat(a_flat), .b_flat(b_flat), .c_flat(c_flat),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input mat_t got, input mat_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic mat_t matmul(input mat_t a, input mat_t b, input mat_t cp, input bit mode);
        mat_t r;
        logic [DW-1:0] s;
        r = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                s = mode ? cp[(i*N+j)*DW +: DW] : '0;
                for (int k = 0; k < N; k++)
                    s = s + a[(i*N+k)*DW +: DW] * b[(k*N+j)*DW +: DW];
                r[(i*N+j)*DW +: DW] = s;
            end
        end
        return r;
    endfunction

    function automatic mat_t pop_exp();
        if (exp_q.size() == 0) return 'x;
        return exp_q.pop_front();
    endfunction

    // One full operation with fixed-count timing checks; optional ignored start pulses.
    task automatic run_op(input string name, input mat_t a, input mat_t b,
                          input bit mode, input bit pulses);
        mat_t old_c;
        old_c    = model_c;
        a_flat   = a;
        b_flat   = b;
        acc_mode = mode;
        start    = 1'b1;
        exp_q.push_back(matmul(a, b, model_c, mode));
        tick();                       // edge E0
        start = 1'b0;
        check({name, "_busy_after_accept"}, mat_t'(busy), mat_t'(1));
        // Operands changing after capture must not matter.
        a_flat   = ~a;
        b_flat   = b ^ {N*N{32'h5a5a_0f0f}};
        acc_mode = ~mode;
        for (int c = 1; c < MAC_CYC; c++) begin
            start = (pulses && c == 5);
            tick();
            if (c == MAC_CYC / 2) check({name, "_c_stable_mid_mac"}, c_flat, old_c);
        end
        start = 1'b0;
        check({name, "_done_low_before_end"}, mat_t'(done), mat_t'(0));
        tick();                       // edge E0+N^3
        check({name, "_done_rise"}, mat_t'(done), mat_t'(1));
        model_c = exp_q[0];
        check({name, "_result"}, c_flat, pop_exp());
        for (int c = MAC_CYC + 1; c < MAC_CYC + OUT_HOLD; c++) begin
            start = (pulses && c == 66);
            tick();
        end
        start = 1'b0;
        check({name, "_done_held"}, mat_t'(done), mat_t'(1));
        tick();                       // edge E0+N^3+OUT_HOLD
        check({name, "_busy_fall"}, mat_t'({busy, done}), mat_t'(0));
        check({name, "_c_hold"}, c_flat, model_c);
    endtask

    initial begin
        int   accepts[$];
        int   n_done;
        bit   prev_busy, prev_done;
        mat_t exp_hold;

        rst = 1'b1; start = 1'b0; acc_mode = 1'b0;
        a_flat = '0; b_flat = '0; model_c = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                ident[(i*N+j)*DW +: DW] = (i == j) ? 32'd1 : 32'd0;
                bseq[(i*N+j)*DW +: DW]  = 32'(i*4 + j);
                ones[(i*N+j)*DW +: DW]  = 32'hffff_ffff;
            end
        end

        // Reset dominates a simultaneous start.
        start = 1'b1;
        tick(); tick();
        rst = 1'b0; start = 1'b0;
        check("reset_c", c_flat, '0);
        check("reset_busy_done", mat_t'({busy, done}), mat_t'(0));
        tick();
        check("idle_no_start", mat_t'(busy), mat_t'(0));

        run_op("ident", ident, bseq, 1'b0, 1'b0);
        run_op("accum", ident, bseq, 1'b1, 1'b0);
        check("accum_is_2b", model_c, matmul(ident, bseq << 0, '0, 1'b0) << 1);
        run_op("all_ones", ones, ones, 1'b0, 1'b0);
        run_op("ignored_starts", ident, bseq, 1'b0, 1'b1);
        for (int t = 0; t < 2; t++) begin
            for (int e = 0; e < N*N; e++) begin
                ra[e*DW +: DW] = $urandom;
                rb[e*DW +: DW] = $urandom;
            end
            run_op($sformatf("rand%0d", t), ra, rb, t[0], 1'b0);
        end

        // Abort mid-MAC: results discarded, c_flat cleared on the next cycle.
        a_flat = ones; b_flat = ones; acc_mode = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 30; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_c = '0;
        check("abort_c_zero", c_flat, '0);
        check("abort_busy_done", mat_t'({busy, done}), mat_t'(0));
        run_op("after_abort", ra, rb, 1'b1, 1'b0);

        // start held high: back-to-back operations 75 cycles apart.
        a_flat = ra; b_flat = bseq; acc_mode = 1'b0; start = 1'b1;
        exp_hold  = matmul(ra, bseq, '0, 1'b0);
        n_done    = 0;
        prev_busy = busy;
        prev_done = done;
        for (int c = 1; c <= 200; c++) begin
            tick();
            if (busy && !prev_busy) begin
                accepts.push_back(c);
                exp_q.push_back(exp_hold);
            end
            if (done && !prev_done) begin
                n_done++;
                check($sformatf("held_result%0d", n_done), c_flat, pop_exp());
            end
            prev_busy = busy;
            prev_done = done;
        end
        start = 1'b0;
        check("held_two_done", mat_t'(n_done), mat_t'(2));
        check("held_gap", mat_t'(accepts.size() >= 2 ? accepts[1] - accepts[0] : 0),
              mat_t'(MAC_CYC + OUT_HOLD + 1));
        for (int c = 0; c < 100 && busy; c++) begin
            tick();
            if (done && !prev_done) check("held_tail_result", c_flat, pop_exp());
            prev_done = done;
        end
        check("held_drain_idle", mat_t'(busy), mat_t'(0));
        check("scoreboard_empty", mat_t'(exp_q.size()), mat_t'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/matrix_mult_seq.md
MATRIX_MULT_SEQ -- requirements
Module: matrix_mult_seq

Interface
REQ-001 Parameter DW, default 32: element width in bits; unsigned elements.
REQ-002 Parameter N, default 4: matrix dimension (N x N); legal range 2..8.
REQ-003 Parameter OUT_HOLD, default 10: cycles `done` stays high after completion; legal range 1..255.
REQ-004 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-005 Port rst  input  1: reset, synchronous, active-high.
REQ-006 Port start  input  1: request a new operation; sampled only in IDLE.
REQ-007 Port acc_mode  input  1: 0 = C = A*B; 1 = C = C_prev + A*B; sampled with start.
REQ-008 Port a_flat  input  N*N*DW: matrix A, row-major; element [i][k] at bits (i*N+k)*DW +: DW.
REQ-009 Port b_flat  input  N*N*DW: matrix B, same packing as A.
REQ-010 Port c_flat  output  N*N*DW: result matrix C, same packing; registered.
REQ-011 Port busy  output  1: high whenever state is not IDLE.
REQ-012 Port done  output  1: high while in the DONE state.

Function
REQ-013 States SHALL be IDLE, MAC, DONE; no other states reachable.
REQ-014 IDLE with start=1 at an edge: capture a_flat, b_flat and acc_mode into internal registers; clear i, j, k and the accumulator; go to MAC.
REQ-015 IDLE with start=0: remain in IDLE; c_flat holds its value.
REQ-016 MAC: one multiply-accumulate per cycle, acc += A[i][k]*B[k][j], using captured operands only.
REQ-017 Index order: k fastest, then j, then i; each index wraps from N-1 to 0.
REQ-018 At k=N-1: write (acc + product), plus C_prev[i][j] if acc_mode=1, into internal result element [i][j]; clear acc.
REQ-019 Arithmetic: full-width product and sum internally; stored element is the low DW bits (modulo 2^DW, no saturation).
REQ-020 C_prev SHALL be the c_flat value at the moment start was accepted.
REQ-021 The MAC phase SHALL last exactly N^3 cycles; at the edge of the final write, the whole result is transferred atomically to c_flat and state goes to DONE.
REQ-022 c_flat SHALL change only at that transfer edge and at reset; it never shows partial results.
REQ-023 DONE SHALL last exactly OUT_HOLD cycles, counted by an internal down-counter, then return to IDLE.
REQ-024 start is ignored in MAC and DONE; changes on a_flat, b_flat and acc_mode after capture have no effect.
REQ-025 Latency: start accepted at edge E0; c_flat valid and done=1 after edge E0+N^3; done falls and busy falls after edge E0+N^3+OUT_HOLD.
REQ-026 A start held high continuously SHALL begin the next operation at the first edge in IDLE (back-to-back throughput N^3+OUT_HOLD+1 cycles).

Reset
REQ-027 rst=1 at an edge: state=IDLE, c_flat=0, busy=0, done=0, i=j=k=0, acc=0, hold counter=0.
REQ-028 rst has priority over all other inputs, including start in the same cycle.
REQ-029 rst asserted mid-MAC or mid-DONE SHALL abort the operation and discard partial results; c_flat reads 0 on the following cycle.

Verification
REQ-030 N=4, A=identity, B[i][j]=i*4+j, acc_mode=0 -> c_flat equals B after edge E0+64; done high for 10 cycles; busy low at E0+74.
REQ-031 Repeat with the same A and B, acc_mode=1 -> each element equals 2*(i*4+j).
REQ-032 DW=32, all A and B elements = 0xFFFF_FFFF, N=4 -> each C element = (4*(2^32-1)^2) mod 2^32 = 0x0000_0004.
REQ-033 Pulse start again at cycles 5 and 66 after acceptance, while busy -> ignored; c_flat and timing identical to REQ-030.
REQ-034 rst pulse at cycle 30 of MAC -> busy=0, done=0, c_flat=0 on the next cycle; a fresh start then completes correctly.
REQ-035 start held high for 200 cycles -> two complete operations with accept edges 75 cycles apart (N=4, OUT_HOLD=10).
